// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first.
// Single full-subtractor cell, borrow flip-flop and shift-register operands.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic             brw;
    logic [CW-1:0]    cnt;
    logic             accept;
    logic             last;
    logic             x;
    logic             y;
    logic             d;
    logic             nb;

    assign last = (cnt == LAST);
    assign busy = (state == SHIFT);
    assign done = (state == DONE);

    // full-subtractor cell
    assign x  = a_sh[0];
    assign y  = b_sh[0];
    assign d  = x ^ y ^ brw;
    assign nb = (~x & y) | (~(x ^ y) & brw);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt    = state;
        accept = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    accept = 1'b1;
                    nxt    = SHIFT;
                end
            end
            SHIFT: begin
                if (last) begin
                    nxt = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    accept = 1'b1;
                    nxt    = SHIFT;
                end else begin
                    nxt = IDLE;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh <= '0;
            b_sh <= '0;
            res  <= '0;
            brw  <= 1'b0;
            cnt  <= '0;
            diff <= '0;
            bout <= 1'b0;
        end else if (accept) begin
            a_sh <= a;
            b_sh <= b;
            brw  <= bin;
            cnt  <= '0;
        end else if (state == SHIFT) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            res  <= {d, res[WIDTH-1:1]};
            brw  <= nb;
            cnt  <= cnt + CW'(1);
            // result registers only move when the final bit lands
            if (last) begin
                diff <= {d, res[WIDTH-1:1]};
                bout <= nb;
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: arithmetic/timing model plus directed vectors.
// Model predicts busy/done/diff/bout every cycle from start/rst history.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;

    int vecs = 0;
    int errs = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .a    (a),
        .b    (b),
        .bin  (bin),
        .busy (busy),
        .done (done),
        .diff (diff),
        .bout (bout)
    );

    always #5 clk = ~clk;

    function automatic logic [W:0] ref_sub(input logic [W-1:0] x,
                                           input logic [W-1:0] y,
                                           input logic z);
        int unsigned r;
        r = {1'b0, x} + (1 << W) - y - z;
        // bit W clear means a borrow was needed
        return {~r[W], r[W-1:0]};
    endfunction

    int         rem = 0;
    logic [W:0] pend = '0;
    logic [W:0] expv = '0;
    bit         armed = 0;

    always @(posedge clk) begin
        if (rst) begin
            rem  = 0;
            expv = '0;
        end else begin
            if (rem == 2) expv = pend;
            if (rem <= 1 && start) begin
                rem  = W + 1;
                pend = ref_sub(a, b, bin);
            end else if (rem > 0) begin
                rem--;
            end
        end
        armed = 1;
    end

    always @(negedge clk) begin
        if (armed) begin
            vecs++;
            if (busy !== (rem > 1) || done !== (rem == 1) ||
                diff !== expv[W-1:0] || bout !== expv[W]) begin
                errs++;
                $display("FAIL cycle: busy=%b done=%b diff=%h bout=%b, want busy=%b done=%b diff=%h bout=%b",
                         busy, done, diff, bout, rem > 1, rem == 1, expv[W-1:0], expv[W]);
            end
        end
    end

    task automatic check(input string nm, input int act, input int want);
        vecs++;
        if (act != want) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", nm, act, want);
        end
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb2,
                          input logic tbin, input int lit, input bit chk);
        int n;
        a     = ta;
        b     = tb2;
        bin   = tbin;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        bin   = 1'($urandom);
        n = 1;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (chk) begin
            check("latency", n, W + 1);
            check("result", int'({bout, diff}), lit);
        end else if (!done) begin
            check("done_timeout", 0, 1);
        end
    endtask

    initial begin
        int nd;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rz;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset_diff", int'(diff), 0);
        check("reset_flags", int'({busy, done, bout}), 0);
        rst = 1'b0;
        @(negedge clk);

        // model pinned against hand-computed values
        check("model_a", int'(ref_sub(8'h35, 8'h12, 1'b0)), 9'h023);
        check("model_b", int'(ref_sub(8'h00, 8'h01, 1'b0)), 9'h1FF);
        check("model_c", int'(ref_sub(8'h80, 8'h7F, 1'b1)), 9'h000);

        run_op(8'h35, 8'h12, 1'b0, 9'h023, 1);
        run_op(8'h12, 8'h35, 1'b0, 9'h1DD, 1);
        run_op(8'h00, 8'h01, 1'b0, 9'h1FF, 1);
        run_op(8'h80, 8'h7F, 1'b1, 9'h000, 1);
        run_op(8'hFF, 8'h00, 1'b1, 9'h0FE, 1);
        run_op(8'h00, 8'hFF, 1'b1, 9'h100, 1);
        @(negedge clk);
        @(negedge clk);

        // start during busy is ignored
        a = 8'h50; b = 8'h20; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nd = 0;
        for (int i = 1; i <= 20; i++) begin
            if (i == 3) begin
                a = 8'hFF; b = 8'hFF; start = 1'b1;
            end
            if (done) begin
                nd++;
                check("ignored_start", int'({bout, diff}), 9'h030);
            end
            @(negedge clk);
            start = 1'b0;
        end
        check("ignored_done_count", nd, 1);

        // reset aborts an operation in flight
        a = 8'h77; b = 8'h11; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_state", int'({busy, done, bout, diff}), 0);
        nd = 0;
        for (int i = 0; i < 15; i++) begin
            if (done) nd++;
            @(negedge clk);
        end
        check("abort_no_done", nd, 0);
        run_op(8'hA0, 8'h0A, 1'b0, 9'h096, 1);
        @(negedge clk);

        // back-to-back with start held high
        a = 8'h09; b = 8'h04; bin = 1'b0; start = 1'b1;
        nd = 0;
        for (int i = 0; i < 27; i++) begin
            @(negedge clk);
            if (done) begin
                nd++;
                check("b2b_result", int'({bout, diff}), 9'h005);
            end
        end
        start = 1'b0;
        check("b2b_done_count", nd, 3);
        @(negedge clk);

        // 1000 random operations, model checks every cycle
        for (int k = 0; k < 1000; k++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rz = 1'($urandom);
            run_op(ra, rb, rz, 0, 0);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
